// File: rtl/mips_debug_controller.sv
// UART-side debug unit: loads instruction memory, runs the CPU (free-running or one clock
// per command) and streams PC, data memory, registers and cycle count back over the UART.
module mips_debug_controller #(
  parameter int IM_ADDR_LENGTH = 32,
  parameter int IM_MEM_SIZE    = 5,
  parameter int INST_WIDTH     = 32,
  parameter int DM_ADDR_LENGTH = 32,
  parameter int DM_MEM_SIZE    = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int RBITS          = 5,
  parameter int BANK_SIZE      = 2,
  parameter int REG_WIDTH      = 32,
  parameter int NBITS          = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NBITS-1:0]          rx_Data,
  input  logic                      rx_done,
  input  logic                      tx_done,
  input  logic [REG_WIDTH-1:0]      RB_Data,
  input  logic [DATA_WIDTH-1:0]     DM_Data,
  input  logic                      halt_flag,
  input  logic [NBITS-1:0]          current_PC,
  input  logic [NBITS-1:0]          clock_count,
  output logic [IM_ADDR_LENGTH-1:0] IM_Addr,
  output logic [INST_WIDTH-1:0]     IM_Data,
  output logic                      IM_We,
  output logic [RBITS-1:0]          RB_Addr,
  output logic [DM_ADDR_LENGTH-1:0] DM_Addr,
  output logic [NBITS-1:0]          tx_Data,
  output logic                      tx_start,
  output logic                      clock_enable,
  output logic                      o_rst
);

  typedef enum logic [2:0] {
    RECVPROG, RECVMODE, RUNSTEP, RUNALL, SENDPC, SENDDM, SENDRB, SENDCLK
  } state_t;

  localparam logic [INST_WIDTH-1:0]     HALT_INST = INST_WIDTH'(32'hFFFF_FFFF);
  localparam logic [NBITS-1:0]          STEP_CMD  = NBITS'(32'h1000_1000);
  localparam logic [IM_ADDR_LENGTH-1:0] IM_LAST   = IM_ADDR_LENGTH'(IM_MEM_SIZE - 1);
  localparam logic [DM_ADDR_LENGTH-1:0] DM_LAST   = DM_ADDR_LENGTH'(DM_MEM_SIZE - 1);
  localparam logic [RBITS-1:0]          RB_LAST   = RBITS'(BANK_SIZE - 1);

  state_t                    state_q;
  logic [IM_ADDR_LENGTH-1:0] im_addr_q;
  logic [INST_WIDTH-1:0]     im_data_q;
  logic                      im_we_q;
  logic [RBITS-1:0]          rb_addr_q;
  logic [DM_ADDR_LENGTH-1:0] dm_addr_q;
  logic [NBITS-1:0]          tx_data_q;
  logic                      tx_start_q;
  logic                      ce_q;
  logic                      o_rst_q;
  logic                      step_q;
  logic                      wait_q;
  logic                      rx_done_q;
  logic                      tx_done_q;
  logic                      rx_evt;
  logic                      tx_evt;
  logic [NBITS-1:0]          send_word_d;

  assign rx_evt = rx_done & ~rx_done_q;
  assign tx_evt = tx_done & ~tx_done_q;

  // Word presented for the current send state; addresses are already settled here.
  always_comb begin
    send_word_d = clock_count;
    case (state_q)
      SENDPC:  send_word_d = current_PC;
      SENDDM:  send_word_d = NBITS'(DM_Data);
      SENDRB:  send_word_d = NBITS'(RB_Data);
      default: send_word_d = clock_count;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RECVPROG;
      im_addr_q  <= '0;
      im_data_q  <= '0;
      im_we_q    <= 1'b0;
      rb_addr_q  <= '0;
      dm_addr_q  <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      ce_q       <= 1'b0;
      o_rst_q    <= 1'b1;
      step_q     <= 1'b0;
      wait_q     <= 1'b0;
      rx_done_q  <= 1'b0;
      tx_done_q  <= 1'b0;
    end else begin
      rx_done_q  <= rx_done;
      tx_done_q  <= tx_done;
      im_we_q    <= 1'b0;
      tx_start_q <= 1'b0;
      case (state_q)
        RECVPROG: begin
          o_rst_q <= 1'b1;
          ce_q    <= 1'b0;
          // The cycle after a write pulse decides between next address and exit.
          if (im_we_q) begin
            if (im_data_q == HALT_INST || im_addr_q == IM_LAST) begin
              im_addr_q <= '0;
              o_rst_q   <= 1'b0;
              state_q   <= RECVMODE;
            end else begin
              im_addr_q <= im_addr_q + IM_ADDR_LENGTH'(1);
            end
          end else if (rx_evt) begin
            im_we_q   <= 1'b1;
            im_data_q <= INST_WIDTH'(rx_Data);
          end
        end
        RECVMODE: begin
          o_rst_q <= 1'b0;
          ce_q    <= 1'b0;
          if (rx_evt) begin
            step_q  <= (rx_Data == STEP_CMD);
            state_q <= (rx_Data == STEP_CMD) ? RUNSTEP : RUNALL;
            ce_q    <= 1'b1;
          end
        end
        RUNSTEP: begin
          ce_q    <= 1'b0;
          state_q <= SENDPC;
        end
        RUNALL: begin
          if (halt_flag) begin
            ce_q    <= 1'b0;
            state_q <= SENDPC;
          end
        end
        default: begin
          ce_q <= 1'b0;
          if (!wait_q) begin
            tx_data_q  <= send_word_d;
            tx_start_q <= 1'b1;
            wait_q     <= 1'b1;
          end else if (tx_evt) begin
            wait_q <= 1'b0;
            case (state_q)
              SENDPC: state_q <= SENDDM;
              SENDDM: begin
                if (dm_addr_q == DM_LAST) state_q <= SENDRB;
                else dm_addr_q <= dm_addr_q + DM_ADDR_LENGTH'(1);
              end
              SENDRB: begin
                if (rb_addr_q == RB_LAST) state_q <= SENDCLK;
                else rb_addr_q <= rb_addr_q + RBITS'(1);
              end
              default: begin
                dm_addr_q <= '0;
                rb_addr_q <= '0;
                if (!step_q || halt_flag) begin
                  state_q   <= RECVPROG;
                  im_addr_q <= '0;
                  o_rst_q   <= 1'b1;
                end else begin
                  state_q <= RECVMODE;
                end
              end
            endcase
          end
        end
      endcase
    end
  end

  assign IM_Addr      = im_addr_q;
  assign IM_Data      = im_data_q;
  assign IM_We        = im_we_q;
  assign RB_Addr      = rb_addr_q;
  assign DM_Addr      = dm_addr_q;
  assign tx_Data      = tx_data_q;
  assign tx_start     = tx_start_q;
  assign clock_enable = ce_q;
  assign o_rst        = o_rst_q;

endmodule

// File: tb/tb_mips_debug_controller.sv
// Directed bench for mips_debug_controller: program load, step and run-to-halt dumps,
// tx back-pressure, IM-full exit and asynchronous reset during a dump.
module tb_mips_debug_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] rx_Data;
  logic        rx_done;
  logic        tx_done;
  logic [31:0] RB_Data;
  logic [31:0] DM_Data;
  logic        halt_flag;
  logic [31:0] current_PC;
  logic [31:0] clock_count;
  logic [31:0] IM_Addr;
  logic [31:0] IM_Data;
  logic        IM_We;
  logic [4:0]  RB_Addr;
  logic [31:0] DM_Addr;
  logic [31:0] tx_Data;
  logic        tx_start;
  logic        clock_enable;
  logic        o_rst;

  int total = 0;
  int bad   = 0;

  mips_debug_controller dut (
    .clk(clk), .reset(reset), .rx_Data(rx_Data), .rx_done(rx_done), .tx_done(tx_done),
    .RB_Data(RB_Data), .DM_Data(DM_Data), .halt_flag(halt_flag), .current_PC(current_PC),
    .clock_count(clock_count), .IM_Addr(IM_Addr), .IM_Data(IM_Data), .IM_We(IM_We),
    .RB_Addr(RB_Addr), .DM_Addr(DM_Addr), .tx_Data(tx_Data), .tx_start(tx_start),
    .clock_enable(clock_enable), .o_rst(o_rst)
  );

  always #5 clk = ~clk;

  // Small memory models answering the DUT's read addresses.
  assign DM_Data = (DM_Addr == 32'd0) ? 32'h0000_0FFF : 32'h0000_0ABC;
  assign RB_Data = (RB_Addr == 5'd0)  ? 32'h0000_0452 : 32'h0000_0077;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load_word(input logic [31:0] w, input logic [31:0] a);
    rx_Data = w;
    rx_done = 1'b1;
    @(negedge clk);
    chk("im_we", {31'd0, IM_We}, 32'd1);
    chk("im_addr", IM_Addr, a);
    chk("im_data", IM_Data, w);
    rx_done = 1'b0;
    @(negedge clk);
    chk("im_we_low", {31'd0, IM_We}, 32'd0);
  endtask

  task automatic send_cmd(input logic [31:0] w);
    rx_Data = w;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic tx_word(input string tag, input logic [31:0] exp);
    int n = 0;
    while (tx_start !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_start"}, {31'd0, tx_start}, 32'd1);
    chk(tag, tx_Data, exp);
    @(negedge clk);
    chk({tag, "_pulse"}, {31'd0, tx_start}, 32'd0);
  endtask

  task automatic ack();
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    reset = 1'b1; rx_Data = '0; rx_done = 1'b0; tx_done = 1'b0;
    halt_flag = 1'b0; current_PC = 32'd2; clock_count = 32'd3;
    repeat (2) @(negedge clk);
    chk("rst_o_rst", {31'd0, o_rst}, 32'd1);
    chk("rst_we", {31'd0, IM_We}, 32'd0);
    chk("rst_ce", {31'd0, clock_enable}, 32'd0);
    chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
    chk("rst_im_addr", IM_Addr, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Program load terminated by the halt word
    load_word(32'h0000_00FF, 32'd0);
    load_word(32'h0000_0023, 32'd1);
    load_word(32'h0000_0789, 32'd2);
    chk("load_o_rst_held", {31'd0, o_rst}, 32'd1);
    load_word(32'hFFFF_FFFF, 32'd3);
    chk("load_o_rst_fall", {31'd0, o_rst}, 32'd0);
    chk("load_addr_clr", IM_Addr, 32'd0);

    // Single step plus back-pressure on the DM[0] acknowledgement
    send_cmd(32'h1000_1000);
    chk("step_ce_on", {31'd0, clock_enable}, 32'd1);
    @(negedge clk);
    chk("step_ce_off", {31'd0, clock_enable}, 32'd0);
    tx_word("s_pc", 32'd2);
    ack();
    tx_word("s_dm0", 32'h0000_0FFF);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (tx_start) seen++;
    end
    chk("hold_no_restart", seen, 32'd0);
    chk("hold_dm_addr", DM_Addr, 32'd0);
    ack();
    tx_word("s_dm1", 32'h0000_0ABC);
    chk("s_dm_addr1", DM_Addr, 32'd1);
    ack();
    tx_word("s_rb0", 32'h0000_0452);
    ack();
    tx_word("s_rb1", 32'h0000_0077);
    chk("s_rb_addr1", {27'd0, RB_Addr}, 32'd1);
    ack();
    tx_word("s_clk", 32'd3);
    ack();
    chk("s_mode_o_rst", {31'd0, o_rst}, 32'd0);
    chk("s_addr_clr", DM_Addr, 32'd0);

    // Run until halt
    current_PC = 32'h0000_0FFF;
    clock_count = 32'd20;
    send_cmd(32'h4500_3000);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (clock_enable) seen++;
      @(negedge clk);
    end
    chk("run_ce_held", seen, 32'd5);
    halt_flag = 1'b1;
    @(negedge clk);
    chk("run_ce_off", {31'd0, clock_enable}, 32'd0);
    tx_word("r_pc", 32'h0000_0FFF);
    ack();
    tx_word("r_dm0", 32'h0000_0FFF);
    ack();
    tx_word("r_dm1", 32'h0000_0ABC);
    ack();
    tx_word("r_rb0", 32'h0000_0452);
    ack();
    tx_word("r_rb1", 32'h0000_0077);
    ack();
    tx_word("r_clk", 32'd20);
    ack();
    chk("run_o_rst", {31'd0, o_rst}, 32'd1);
    halt_flag = 1'b0;

    // Exit on IM full without a halt word
    for (int i = 0; i < 5; i++) begin
      load_word(32'h0000_0100 + i, i);
    end
    chk("full_o_rst", {31'd0, o_rst}, 32'd0);
    chk("full_addr_clr", IM_Addr, 32'd0);

    // Asynchronous reset while dumping data memory
    current_PC = 32'd7;
    send_cmd(32'h1000_1000);
    tx_word("a_pc", 32'd7);
    ack();
    tx_word("a_dm0", 32'h0000_0FFF);
    ack();
    chk("a_dm_addr_pre", DM_Addr, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("a_o_rst", {31'd0, o_rst}, 32'd1);
    chk("a_dm_addr", DM_Addr, 32'd0);
    chk("a_tx_data", tx_Data, 32'd0);
    chk("a_tx_start", {31'd0, tx_start}, 32'd0);
    chk("a_ce", {31'd0, clock_enable}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    load_word(32'hFFFF_FFFF, 32'd0);
    chk("a_reload_mode", {31'd0, o_rst}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
